// File: rtl/uart_cmd_parser_pkg.sv
// Shared definitions for the UART command parser: opcode bytes, error codes,
// the one-hot parser state encoding and the command being assembled.
package uart_cmd_pkg;

   // Opcode bytes recognised while the parser is idle
   localparam logic [7:0] OP_ROW    = 8'h4C;
   localparam logic [7:0] OP_BRIGHT = 8'h42;
   localparam logic [7:0] OP_SWAP   = 8'h53;

   // Values presented on o_err_code; the last error sticks until the next one
   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_CSUM    = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;

   // One-hot parser states, same encoding style as the UART receiver
   typedef enum logic [4:0] {
      ST_IDLE    = 5'b00001,
      ST_ROW     = 5'b00010,
      ST_PAYLOAD = 5'b00100,
      ST_BRIGHT  = 5'b01000,
      ST_CHECK   = 5'b10000
   } parser_state_t;

   // Which command the checksum byte will complete
   typedef enum logic [1:0] {
      CMD_ROW    = 2'd0,
      CMD_BRIGHT = 2'd1,
      CMD_SWAP   = 2'd2
   } cmd_t;

   // Maps an opcode byte to the first state of its packet; any other byte
   // keeps the parser idle so line noise is dropped without complaint.
   function automatic parser_state_t opcodeTarget(input logic [7:0] opcode);
      parser_state_t target;
      target = ST_IDLE;
      case (opcode)
         OP_ROW:    target = ST_ROW;
         OP_BRIGHT: target = ST_BRIGHT;
         OP_SWAP:   target = ST_CHECK;
         default:   target = ST_IDLE;
      endcase
      return target;
   endfunction

   // Maps an opcode byte to the command it starts (only meaningful for opcodes)
   function automatic cmd_t opcodeCmd(input logic [7:0] opcode);
      cmd_t cmd;
      cmd = CMD_ROW;
      case (opcode)
         OP_BRIGHT: cmd = CMD_BRIGHT;
         OP_SWAP:   cmd = CMD_SWAP;
         default:   cmd = CMD_ROW;
      endcase
      return cmd;
   endfunction

endpackage

// File: rtl/uart_cmd_parser_byte_timeout.sv
// Inter-byte watchdog for the command parser. Counts idle clocks while a
// packet is open and flags the cycle on which the allowance runs out.
module byte_timeout #(
   parameter int TIMEOUT_TICKS = 65535,
   parameter int TIMEOUT_WIDTH = 16
) (
   input  logic i_clk,
   input  logic reset_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [TIMEOUT_WIDTH-1:0] LAST_TICK = TIMEOUT_WIDTH'(TIMEOUT_TICKS - 1);

   logic [TIMEOUT_WIDTH-1:0] idleCount;

   // Expiry is only declared when no byte arrives on the final tick, so a
   // strobe landing exactly on that cycle always wins over the timeout.
   assign expired = enable && !clear && (idleCount == LAST_TICK);

   // The count restarts on every byte, stays at zero while the parser is
   // idle, and also restarts after expiry because the parser drops back to
   // idle on that same edge.
   always_ff @(posedge i_clk or negedge reset_n) begin
      if (!reset_n) begin
         idleCount <= '0;
      end else if (clear || !enable || expired) begin
         idleCount <= '0;
      end else begin
         idleCount <= idleCount + TIMEOUT_WIDTH'(1);
      end
   end

endmodule

// File: rtl/uart_cmd_parser.sv
// Byte-stream command parser downstream of the UART receiver. Decodes row
// payload writes, brightness updates and buffer swaps, each closed by an XOR
// checksum, and drops packets that stall between bytes.
module uart_cmd_parser
   import uart_cmd_pkg::*;
#(
   parameter int         ROWS           = 32,
   parameter int         ROW_ADDR_WIDTH = 5,
   parameter int         ROW_BYTES      = 128,
   parameter int         COL_ADDR_WIDTH = 7,
   parameter int         TIMEOUT_TICKS  = 65535,
   parameter int         TIMEOUT_WIDTH  = 16,
   parameter logic [7:0] BRIGHT_RESET   = 8'hFF
) (
   input  logic                                   i_clk,
   input  logic                                   reset_n,
   input  logic [7:0]                             i_rxdata,
   input  logic                                   i_recvdata,
   output logic                                   o_wr_en,
   output logic [ROW_ADDR_WIDTH+COL_ADDR_WIDTH-1:0] o_wr_addr,
   output logic [7:0]                             o_wr_data,
   output logic [7:0]                             o_brightness,
   output logic                                   o_swap,
   output logic                                   o_err,
   output logic [1:0]                             o_err_code,
   output logic                                   o_busy
);

   localparam logic [COL_ADDR_WIDTH-1:0] LAST_BYTE = COL_ADDR_WIDTH'(ROW_BYTES - 1);

   // Parameter sanity: the row field must be able to address every display
   // row and the byte index must cover a whole row. These blocks carry no
   // logic; they exist so a bad override is visible in the elaborated tree.
   if (ROWS > (1 << ROW_ADDR_WIDTH)) begin : gRowsExceedRowField
   end
   if (ROW_BYTES > (1 << COL_ADDR_WIDTH)) begin : gRowBytesExceedColField
   end

   parser_state_t                state;
   cmd_t                         activeCmd;
   logic [7:0]                   checksumAcc;
   logic [7:0]                   pendingBright;
   logic [ROW_ADDR_WIDTH-1:0]    rowAddr;
   logic [COL_ADDR_WIDTH-1:0]    byteIndex;
   logic                         timerEnable;
   logic                         timeoutExpired;

   // The watchdog only runs while a packet is open
   assign timerEnable = (state != ST_IDLE);

   byte_timeout #(
      .TIMEOUT_TICKS(TIMEOUT_TICKS),
      .TIMEOUT_WIDTH(TIMEOUT_WIDTH)
   ) uByteTimeout (
      .i_clk   (i_clk),
      .reset_n (reset_n),
      .clear   (i_recvdata),
      .enable  (timerEnable),
      .expired (timeoutExpired)
   );

   // Packet FSM plus every registered output. Pulse outputs default low each
   // cycle; a received byte always takes priority over the timeout, and a
   // reset throws away any half-built packet without emitting anything.
   always_ff @(posedge i_clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= ST_IDLE;
         activeCmd     <= CMD_ROW;
         checksumAcc   <= 8'h00;
         pendingBright <= 8'h00;
         rowAddr       <= '0;
         byteIndex     <= '0;
         o_wr_en       <= 1'b0;
         o_wr_addr     <= '0;
         o_wr_data     <= 8'h00;
         o_brightness  <= BRIGHT_RESET;
         o_swap        <= 1'b0;
         o_err         <= 1'b0;
         o_err_code    <= ERR_NONE;
         o_busy        <= 1'b0;
      end else begin
         o_wr_en <= 1'b0;
         o_swap  <= 1'b0;
         o_err   <= 1'b0;

         if (i_recvdata) begin
            case (state)
               ST_IDLE: begin
                  if (opcodeTarget(i_rxdata) != ST_IDLE) begin
                     state       <= opcodeTarget(i_rxdata);
                     activeCmd   <= opcodeCmd(i_rxdata);
                     checksumAcc <= i_rxdata;
                     o_busy      <= 1'b1;
                  end
               end

               ST_ROW: begin
                  rowAddr     <= i_rxdata[ROW_ADDR_WIDTH-1:0];
                  byteIndex   <= '0;
                  checksumAcc <= checksumAcc ^ i_rxdata;
                  state       <= ST_PAYLOAD;
               end

               ST_PAYLOAD: begin
                  o_wr_en     <= 1'b1;
                  o_wr_addr   <= {rowAddr, byteIndex};
                  o_wr_data   <= i_rxdata;
                  checksumAcc <= checksumAcc ^ i_rxdata;
                  byteIndex   <= byteIndex + COL_ADDR_WIDTH'(1);
                  if (byteIndex == LAST_BYTE) begin
                     state <= ST_CHECK;
                  end
               end

               ST_BRIGHT: begin
                  pendingBright <= i_rxdata;
                  checksumAcc   <= checksumAcc ^ i_rxdata;
                  state         <= ST_CHECK;
               end

               ST_CHECK: begin
                  state       <= ST_IDLE;
                  checksumAcc <= 8'h00;
                  o_busy      <= 1'b0;
                  if (i_rxdata == checksumAcc) begin
                     case (activeCmd)
                        CMD_BRIGHT: o_brightness <= pendingBright;
                        CMD_SWAP:   o_swap       <= 1'b1;
                        default:    ;
                     endcase
                  end else begin
                     o_err      <= 1'b1;
                     o_err_code <= ERR_CSUM;
                  end
               end

               default: begin
                  state       <= ST_IDLE;
                  checksumAcc <= 8'h00;
                  o_busy      <= 1'b0;
               end
            endcase
         end else if (timeoutExpired) begin
            state       <= ST_IDLE;
            checksumAcc <= 8'h00;
            o_busy      <= 1'b0;
            o_err       <= 1'b1;
            o_err_code  <= ERR_TIMEOUT;
         end
      end
   end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser with a 4-byte row and a 50-clock
// inter-byte timeout. Expected writes, swaps and errors are queued as bytes
// are driven and retired by a monitor as the DUT produces them.
module tb_uart_cmd_parser;

   localparam int EV_WRITE = 1;
   localparam int EV_SWAP  = 2;
   localparam int EV_ERR   = 3;

   typedef struct {
      int         kind;
      logic [6:0] addr;
      logic [7:0] data;
   } expEvent_t;

   logic       i_clk;
   logic       reset_n;
   logic [7:0] i_rxdata;
   logic       i_recvdata;
   logic       o_wr_en;
   logic [6:0] o_wr_addr;
   logic [7:0] o_wr_data;
   logic [7:0] o_brightness;
   logic       o_swap;
   logic       o_err;
   logic [1:0] o_err_code;
   logic       o_busy;

   int testsRun;
   int testsFailed;
   expEvent_t expQ[$];
   expEvent_t monEvent;
   int monKind;

   uart_cmd_parser #(
      .ROWS           (32),
      .ROW_ADDR_WIDTH (5),
      .ROW_BYTES      (4),
      .COL_ADDR_WIDTH (2),
      .TIMEOUT_TICKS  (50),
      .TIMEOUT_WIDTH  (16),
      .BRIGHT_RESET   (8'hFF)
   ) dut (
      .i_clk        (i_clk),
      .reset_n      (reset_n),
      .i_rxdata     (i_rxdata),
      .i_recvdata   (i_recvdata),
      .o_wr_en      (o_wr_en),
      .o_wr_addr    (o_wr_addr),
      .o_wr_data    (o_wr_data),
      .o_brightness (o_brightness),
      .o_swap       (o_swap),
      .o_err        (o_err),
      .o_err_code   (o_err_code),
      .o_busy       (o_busy)
   );

   // 10-unit system clock
   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Drives one byte with a one-cycle strobe; called on a falling edge and
   // returns on the next, so consecutive calls give back-to-back strobes
   task automatic applyStimulus(input logic [7:0] b);
      i_rxdata   = b;
      i_recvdata = 1'b1;
      @(negedge i_clk);
      i_recvdata = 1'b0;
   endtask

   task automatic idleCycles(input int n);
      repeat (n) @(negedge i_clk);
   endtask

   task automatic pushWrite(input logic [6:0] addr, input logic [7:0] data);
      expEvent_t e;
      e.kind = EV_WRITE; e.addr = addr; e.data = data;
      expQ.push_back(e);
   endtask

   task automatic pushSwap();
      expEvent_t e;
      e.kind = EV_SWAP; e.addr = '0; e.data = '0;
      expQ.push_back(e);
   endtask

   task automatic pushErr(input logic [1:0] code);
      expEvent_t e;
      e.kind = EV_ERR; e.addr = '0; e.data = {6'b0, code};
      expQ.push_back(e);
   endtask

   // Lets the monitor retire anything due this edge, then requires an empty queue
   task automatic checkDrained(input string tag);
      #1;
      checkOutput(tag, expQ.size(), 0);
   endtask

   // Monitor: every strobe the DUT raises must match the oldest expectation
   always @(negedge i_clk) begin
      if (reset_n && (o_wr_en || o_swap || o_err)) begin
         monKind = o_wr_en ? EV_WRITE : (o_swap ? EV_SWAP : EV_ERR);
         if (expQ.size() == 0) begin
            checkOutput("unexpected_event", monKind, 0);
         end else begin
            monEvent = expQ.pop_front();
            checkOutput("event_kind", monKind, monEvent.kind);
            if (monEvent.kind == EV_WRITE) begin
               checkOutput("wr_addr", o_wr_addr, monEvent.addr);
               checkOutput("wr_data", o_wr_data, monEvent.data);
            end else if (monEvent.kind == EV_ERR) begin
               checkOutput("err_code_at_pulse", o_err_code, monEvent.data);
            end
         end
      end
   end

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      reset_n     = 1'b0;
      i_recvdata  = 1'b0;
      i_rxdata    = 8'h00;
      idleCycles(3);

      checkOutput("rst_wr_en", o_wr_en, 0);
      checkOutput("rst_wr_addr", o_wr_addr, 0);
      checkOutput("rst_wr_data", o_wr_data, 0);
      checkOutput("rst_bright", o_brightness, 8'hFF);
      checkOutput("rst_swap", o_swap, 0);
      checkOutput("rst_err", o_err, 0);
      checkOutput("rst_err_code", o_err_code, 0);
      checkOutput("rst_busy", o_busy, 0);
      reset_n = 1'b1;
      idleCycles(1);

      // Row write, back-to-back bytes
      pushWrite(7'h0C, 8'h11);
      pushWrite(7'h0D, 8'h22);
      pushWrite(7'h0E, 8'h33);
      pushWrite(7'h0F, 8'h44);
      applyStimulus(8'h4C);
      checkOutput("row_busy_rise", o_busy, 1);
      applyStimulus(8'h03);
      applyStimulus(8'h11);
      applyStimulus(8'h22);
      applyStimulus(8'h33);
      applyStimulus(8'h44);
      checkOutput("row_busy_before_csum", o_busy, 1);
      applyStimulus(8'h0B);
      checkOutput("row_busy_fall", o_busy, 0);
      checkOutput("row_err_code", o_err_code, 0);
      checkDrained("row_drained");

      // Brightness good, then bad checksum
      applyStimulus(8'h42);
      applyStimulus(8'h80);
      checkOutput("bright_pending_hidden", o_brightness, 8'hFF);
      applyStimulus(8'hC2);
      checkOutput("bright_commit", o_brightness, 8'h80);
      pushErr(2'b01);
      applyStimulus(8'h42);
      applyStimulus(8'h10);
      applyStimulus(8'h00);
      checkOutput("bright_bad_keeps", o_brightness, 8'h80);
      checkOutput("bright_bad_code", o_err_code, 2'b01);
      checkOutput("bright_bad_busy", o_busy, 0);
      checkDrained("bright_drained");

      // Noise then swap
      pushSwap();
      applyStimulus(8'h00);
      checkOutput("noise_not_busy", o_busy, 0);
      applyStimulus(8'h7F);
      checkOutput("noise2_not_busy", o_busy, 0);
      applyStimulus(8'h53);
      applyStimulus(8'h53);
      checkOutput("swap_code_holds", o_err_code, 2'b01);
      checkDrained("swap_drained");

      // Timeout mid-payload, then recovery
      pushWrite(7'h04, 8'hAA);
      pushErr(2'b10);
      applyStimulus(8'h4C);
      applyStimulus(8'h01);
      applyStimulus(8'hAA);
      idleCycles(49);
      checkOutput("tmo_not_yet_busy", o_busy, 1);
      checkOutput("tmo_not_yet_code", o_err_code, 2'b01);
      idleCycles(1);
      checkOutput("tmo_busy_drop", o_busy, 0);
      checkOutput("tmo_code", o_err_code, 2'b10);
      pushSwap();
      applyStimulus(8'h53);
      applyStimulus(8'h53);
      checkDrained("tmo_drained");

      // Strobes landing exactly on the expiry cycle must win
      applyStimulus(8'h42);
      idleCycles(49);
      applyStimulus(8'h20);
      idleCycles(49);
      applyStimulus(8'h62);
      checkOutput("edge_bright", o_brightness, 8'h20);
      checkOutput("edge_code_holds", o_err_code, 2'b10);
      checkOutput("edge_busy", o_busy, 0);
      checkDrained("edge_drained");

      // Reset mid-payload
      pushWrite(7'h08, 8'h55);
      pushWrite(7'h09, 8'h66);
      applyStimulus(8'h4C);
      applyStimulus(8'h02);
      applyStimulus(8'h55);
      applyStimulus(8'h66);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("mid_rst_wr_en", o_wr_en, 0);
      checkOutput("mid_rst_wr_addr", o_wr_addr, 0);
      checkOutput("mid_rst_wr_data", o_wr_data, 0);
      checkOutput("mid_rst_bright", o_brightness, 8'hFF);
      checkOutput("mid_rst_err_code", o_err_code, 0);
      checkOutput("mid_rst_busy", o_busy, 0);
      checkOutput("mid_rst_queue", expQ.size(), 0);
      idleCycles(2);
      reset_n = 1'b1;
      idleCycles(1);
      applyStimulus(8'h77);
      applyStimulus(8'h88);
      checkOutput("post_rst_idle", o_busy, 0);

      // Full packet after reset; row byte 0x3F keeps only its low five bits
      pushWrite(7'h7C, 8'hA1);
      pushWrite(7'h7D, 8'hB2);
      pushWrite(7'h7E, 8'hC3);
      pushWrite(7'h7F, 8'hD4);
      applyStimulus(8'h4C);
      applyStimulus(8'h3F);
      applyStimulus(8'hA1);
      applyStimulus(8'hB2);
      applyStimulus(8'hC3);
      applyStimulus(8'hD4);
      applyStimulus(8'h77);
      checkOutput("final_busy", o_busy, 0);
      checkOutput("final_code", o_err_code, 0);
      checkOutput("final_bright", o_brightness, 8'hFF);
      checkDrained("final_drained");

      idleCycles(2);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Byte-stream command parser sitting directly downstream of the UART receiver. It consumes each received byte plus its one-cycle valid strobe and decodes framed commands. Row-pixel payloads become frame-buffer write strobes; brightness updates and buffer-swap requests go to the display controller. Malformed or stalled packets are dropped and flagged.

## Interface
Parameters:
- `ROWS`, 32: number of display rows.
- `ROW_ADDR_WIDTH`, 5: width of the row field in the write address.
- `ROW_BYTES`, 128: payload bytes per row command (64 px × 2 B).
- `COL_ADDR_WIDTH`, 7: width of the byte-index field, ≥ clog2(`ROW_BYTES`).
- `TIMEOUT_TICKS`, 65535: idle clocks allowed between bytes of one packet.
- `TIMEOUT_WIDTH`, 16: timeout counter width.
- `BRIGHT_RESET`, 8'hFF: brightness value held after reset.

Ports:
- `i_clk`  in  1: system clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `i_rxdata`  in  8: received byte, valid only while `i_recvdata`=1.
- `i_recvdata`  in  1: one-cycle byte-valid strobe.
- `o_wr_en`  out  1: one-cycle frame-buffer write strobe.
- `o_wr_addr`  out  `ROW_ADDR_WIDTH+COL_ADDR_WIDTH`: {row, byte index}.
- `o_wr_data`  out  8: payload byte.
- `o_brightness`  out  8: current brightness.
- `o_swap`  out  1: one-cycle buffer-swap pulse.
- `o_err`  out  1: one-cycle error pulse.
- `o_err_code`  out  2: 01 checksum, 10 timeout; holds until the next error.
- `o_busy`  out  1: high whenever the state is not IDLE.

## Operation
- Opcodes: `L`=0x4C (row write), `B`=0x42 (brightness), `S`=0x53 (swap). In IDLE, any other byte is ignored silently.
- Packet formats:
  - `L`: row, `ROW_BYTES` payload bytes, checksum.
  - `B`: value, checksum.
  - `S`: checksum.
- Checksum rule:
  - Running XOR starts at 0 and includes the opcode byte.
  - It covers every byte before the checksum byte.
  - The packet is valid when the checksum byte equals the accumulator.
- States: IDLE, ROW, PAYLOAD, BRIGHT, CHECK.
  - IDLE: `L`→ROW, `B`→BRIGHT, `S`→CHECK.
  - ROW: latch row[`ROW_ADDR_WIDTH`-1:0] (upper bits discarded), clear the byte index, →PAYLOAD.
  - PAYLOAD: each byte produces a write at {row, index}, then index+1. After byte `ROW_BYTES`-1 →CHECK.
  - BRIGHT: latch a pending value, →CHECK.
  - CHECK: on the checksum byte →IDLE.
    - Match: `B` commits the pending value to `o_brightness`; `S` pulses `o_swap`; `L` has no further action.
    - Mismatch: `o_err`=1, `o_err_code`=01. A pending brightness value is discarded.
- Payload writes are not held back on a bad checksum. The display controller ignores a row whose packet errored. This is documented, not corrected here.
- Timeout:
  - The counter clears on every strobe and counts while the state is not IDLE.
  - Reaching `TIMEOUT_TICKS`-1 with no strobe sends the FSM to IDLE, pulses `o_err`, and sets `o_err_code`=10.
  - The counter holds at 0 in IDLE.
- Reset values: `o_wr_en`=0, `o_wr_addr`=0, `o_wr_data`=0, `o_brightness`=`BRIGHT_RESET`, `o_swap`=0, `o_err`=0, `o_err_code`=00, `o_busy`=0. State is IDLE and the accumulator is 0.
- Reset mid-packet aborts the packet immediately. No write, swap or error is issued.

## Timing
- All outputs are registered.
- `o_wr_en`, `o_wr_addr` and `o_wr_data` appear on the cycle after the strobe of the payload byte.
- `o_swap`, `o_err` and the `o_brightness` update appear on the cycle after the checksum strobe.
- The block accepts strobes on consecutive cycles with no byte loss.
- A strobe arriving on the same cycle as timeout expiry wins: the byte is processed and no timeout is raised.
- A new opcode may arrive on the cycle right after a checksum byte and is decoded normally.
- `o_busy` rises one cycle after the opcode strobe and falls one cycle after the final byte.

## Structure
- Shared package `uart_cmd_pkg`:
  - opcode constants `OP_ROW`, `OP_BRIGHT`, `OP_SWAP`;
  - error codes `ERR_NONE`, `ERR_CSUM`, `ERR_TIMEOUT`;
  - state encoding, one-hot, matching the receiver's style.
- One sub-module is natural: `byte_timeout`, a timeout counter with clear, enable and expiry pulse.
- The FSM, accumulator and output registers stay in the top module.

## Test plan
Bench overrides: `ROW_BYTES`=4, `COL_ADDR_WIDTH`=2, `TIMEOUT_TICKS`=50.
- Row write: send 4C 03 11 22 33 44 0B → writes to addresses 0x0C/0x0D/0x0E/0x0F with data 11/22/33/44; no `o_err`; `o_busy` low afterwards.
- Brightness: send 42 80 C2 → `o_brightness` changes from FF to 80 one cycle after C2. Then send 42 10 00 → `o_err`=1, `o_err_code`=01, brightness stays 80.
- Swap, preceded by noise: send 00 7F 53 53 → noise ignored; one `o_swap` pulse; no error.
- Timeout: send 4C 01 AA, then no strobe for 50 clocks → `o_err_code`=10 with one `o_err` pulse, state IDLE. A following 53 53 → `o_swap`.
- Back-to-back strobes on consecutive cycles, plus a strobe exactly on the expiry cycle → every byte is processed and no spurious timeout occurs.
- Deassert `reset_n` mid-payload → all outputs return to their reset values and no further writes occur. After release, a full valid row packet executes correctly.
